// File: rtl/data_read_axi_read_pkg.sv
// Shared constants for the data_read read channel: register offsets, SR bit
// positions, AXI response codes and FSM state encodings.
package data_read_axi_read_pkg;

    localparam logic [7:0] AXI_ADDR_CR  = 8'h00;
    localparam logic [7:0] AXI_ADDR_SR  = 8'h04;
    localparam logic [7:0] AXI_ADDR_DR  = 8'h08;
    localparam logic [7:0] AXI_ADDR_CNT = 8'h0C;

    localparam int SR_BUSY_BIT     = 0;
    localparam int SR_DONE_BIT     = 1;
    localparam int SR_EMPTY_BIT    = 2;
    localparam int SR_UNDERRUN_BIT = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Register index is the word offset within the 16-byte map.
    typedef enum logic [1:0] {
        REG_CR  = AXI_ADDR_CR[3:2],
        REG_SR  = AXI_ADDR_SR[3:2],
        REG_DR  = AXI_ADDR_DR[3:2],
        REG_CNT = AXI_ADDR_CNT[3:2]
    } reg_sel_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_result_t;

endpackage

// File: rtl/data_read_axi_read.sv
// AXI4-Lite read-channel slave for data_read: returns CR/SR/DR/CNT, pops the
// FWFT capture FIFO on DR reads and keeps the clear-on-read DONE/UNDERRUN flags.
module data_read_axi_read
    import data_read_axi_read_pkg::*;
#(
    parameter int C_FIFO_CNT_WIDTH = 11,
    parameter int C_ADDR_LSB       = 2
) (
    input  logic                        S_AXI_ACLK,
    input  logic                        S_AXI_ARESET,
    input  logic [31:0]                 S_AXI_ARADDR,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [31:0]                 S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    input  logic                        busy,
    input  logic                        done_pulse,
    input  logic [31:0]                 fifo_dout,
    input  logic                        fifo_empty,
    input  logic [C_FIFO_CNT_WIDTH-1:0] fifo_count,
    output logic                        fifo_rd_en
);

    state_t      state_reg, state_next;
    reg_sel_t    reg_sel_reg;
    logic        misaligned_reg;
    logic        pop_reg;
    logic [31:0] rdata_reg;
    logic [1:0]  rresp_reg;
    logic        done_reg;
    logic        underrun_reg;

    logic        in_addr;
    logic        sr_clear;
    logic        underrun_event;
    logic [31:0] sr_word;
    logic [31:0] cnt_word;
    reg_sel_t    araddr_sel;
    logic        araddr_misaligned;
    rd_result_t  result;

    function automatic rd_result_t capture(
        input reg_sel_t    sel,
        input logic        misaligned,
        input logic        pop,
        input logic [31:0] sr_value,
        input logic [31:0] head,
        input logic [31:0] cnt_value
    );
        rd_result_t r;
        r.data = '0;
        r.resp = RESP_OKAY;
        if (misaligned) begin
            r.resp = RESP_SLVERR;
        end else begin
            case (sel)
                REG_CR:  r.data = '0;
                REG_SR:  r.data = sr_value;
                REG_DR: begin
                    if (pop) r.data = head;
                    else     r.resp = RESP_SLVERR;
                end
                REG_CNT: r.data = cnt_value;
                default: r.data = '0;
            endcase
        end
        return r;
    endfunction

    assign araddr_sel        = reg_sel_t'(S_AXI_ARADDR[C_ADDR_LSB+1:C_ADDR_LSB]);
    assign araddr_misaligned = |S_AXI_ARADDR[C_ADDR_LSB-1:0];

    assign in_addr        = (state_reg == ST_ADDR);
    assign sr_clear       = in_addr && !misaligned_reg && (reg_sel_reg == REG_SR);
    assign underrun_event = in_addr && !misaligned_reg && (reg_sel_reg == REG_DR) && !pop_reg;
    assign cnt_word       = 32'(fifo_count);

    always_comb begin
        sr_word                  = '0;
        sr_word[SR_BUSY_BIT]     = busy;
        sr_word[SR_DONE_BIT]     = done_reg;
        sr_word[SR_EMPTY_BIT]    = fifo_empty;
        sr_word[SR_UNDERRUN_BIT] = underrun_reg;
    end

    assign result = capture(reg_sel_reg, misaligned_reg, pop_reg, sr_word, fifo_dout, cnt_word);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (S_AXI_ARVALID) state_next = ST_ADDR;
            ST_ADDR: state_next = ST_RESP;
            ST_RESP: if (S_AXI_RREADY) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_reg      <= ST_IDLE;
            reg_sel_reg    <= REG_CR;
            misaligned_reg <= 1'b0;
            pop_reg        <= 1'b0;
            rdata_reg      <= '0;
            rresp_reg      <= RESP_OKAY;
            done_reg       <= 1'b0;
            underrun_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pop_reg   <= 1'b0;
            // Decode on acceptance into ADDR so the pop strobe is a plain register
            // during ADDR; only this block reads the FIFO, so non-empty stays true.
            if (state_reg == ST_IDLE && S_AXI_ARVALID) begin
                reg_sel_reg    <= araddr_sel;
                misaligned_reg <= araddr_misaligned;
                pop_reg        <= !araddr_misaligned && (araddr_sel == REG_DR) && !fifo_empty;
            end
            if (in_addr) begin
                rdata_reg <= result.data;
                rresp_reg <= result.resp;
            end
            // Set beats clear when an event lands on the clearing SR read.
            done_reg     <= done_pulse || (done_reg && !sr_clear);
            underrun_reg <= underrun_event || (underrun_reg && !sr_clear);
        end
    end

    assign S_AXI_ARREADY = (state_reg == ST_ADDR);
    assign S_AXI_RVALID  = (state_reg == ST_RESP);
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = rresp_reg;
    // Suppress the pop in a reset cycle so an aborted DR read never loses a word.
    assign fifo_rd_en    = pop_reg && !S_AXI_ARESET;

endmodule
